msg_unpack: RTL and testbench

Message unpacker directly upstream of the Encode stage. It accepts the plaintext message μ as a stream of 64-bit words and produces the 64 message chunks of the 8×8 matrix as 16 beats. Each beat holds four coefficients in four 16-bit lanes, each lane carrying B message bits zero-extended. B is selected by security level. The output feeds Encode's `input_data` directly; Encode's `level` uses the same encoding.

---
 rtl/msg_unpack.sv | 118 +++++++++++
 tb/tb_msg_unpack.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/msg_unpack.sv
// msg_unpack: turns 2..4 message words into 16 beats of four zero-extended B-bit chunks.
// Revision: 1.0
`default_nettype none

module msg_unpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  level,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]   state;
  logic [1:0]   level_q;
  logic [2:0]   word_cnt;
  logic [3:0]   beat_cnt;
  logic [7:0]   bit_cnt;
  logic [127:0] msg_buf;
  logic         done_q;

  logic [2:0]   bits_per;
  logic [7:0]   step;
  logic         pop;
  logic         push;
  logic [7:0]   cnt_pop;
  logic [127:0] buf_pop;
  logic [127:0] buf_next;
  logic [7:0]   cnt_next;

  // B and the word count coincide numerically for every legal level.
  always_comb begin
    case (level_q)
      2'b01:   bits_per = 3'd4;
      2'b10:   bits_per = 3'd3;
      default: bits_per = 3'd2;
    endcase
  end

  assign step      = {3'b000, bits_per, 2'b00};
  assign busy      = (state == RUN);
  assign out_valid = (state == RUN) && (bit_cnt >= step);
  assign out_last  = out_valid && (beat_cnt == 4'd15);
  assign done      = done_q;

  assign pop     = out_valid && out_ready;
  assign cnt_pop = pop ? (bit_cnt - step) : bit_cnt;
  assign buf_pop = pop ? (msg_buf >> step) : msg_buf;

  // Pop is applied first so a draining beat frees room for the next word.
  assign in_ready = (state == RUN) && (word_cnt < bits_per) && (cnt_pop <= 8'd64);
  assign push     = in_valid && in_ready;

  assign buf_next = push ? (buf_pop | ({64'd0, in_data} << cnt_pop)) : buf_pop;
  assign cnt_next = push ? (cnt_pop + 8'd64) : cnt_pop;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 4; i++) begin
      case (level_q)
        2'b01:   out_data[16*i +: 16] = {12'd0, msg_buf[4*i +: 4]};
        2'b10:   out_data[16*i +: 16] = {13'd0, msg_buf[3*i +: 3]};
        default: out_data[16*i +: 16] = {14'd0, msg_buf[2*i +: 2]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level_q  <= 2'b00;
      word_cnt <= 3'd0;
      beat_cnt <= 4'd0;
      bit_cnt  <= 8'd0;
      msg_buf  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (level != 2'b00)) begin
            state    <= RUN;
            level_q  <= level;
            word_cnt <= 3'd0;
            beat_cnt <= 4'd0;
            bit_cnt  <= 8'd0;
            msg_buf  <= '0;
          end
        end
        default: begin
          msg_buf <= buf_next;
          bit_cnt <= cnt_next;
          if (push) word_cnt <= word_cnt + 3'd1;
          if (pop) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (beat_cnt == 4'd15) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_msg_unpack.sv
// tb_msg_unpack: random and directed stimulus against a bit-extraction model of the unpacker.
// Revision: 1.0
`default_nettype none

module tb_msg_unpack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  level;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  msg_unpack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .level    (level),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the accepted message as a flat bit array; coefficient k is bits [kB+B-1:kB].
  logic [255:0] msg_bits;
  logic [63:0]  got_beat [16];
  bit           run_m = 1'b0;
  bit           done_m = 1'b0;
  int           mb = 0, wt = 0, ws = 0, beats = 0;
  bit           prev_stall = 1'b0;
  logic [63:0]  prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    int avail, k, lane;
    bit ev, pm, ei, was_run;
    logic [63:0]  expd;
    logic [255:0] t;
    if (armed) begin
      if (!rst_n) begin
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        run_m = 0; done_m = 0; beats = 0; ws = 0; prev_stall = 0;
      end else begin
        avail = 64 * ws - 4 * mb * beats;
        ev = run_m && (avail >= 4 * mb);
        pm = ev && out_ready;
        ei = run_m && (ws < wt) && ((avail - (pm ? 4 * mb : 0)) <= 64);
        chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
        chk("in_ready", {63'd0, in_ready}, {63'd0, ei});
        chk("busy", {63'd0, busy}, {63'd0, run_m});
        chk("done", {63'd0, done}, {63'd0, done_m});
        chk("out_last", {63'd0, out_last}, {63'd0, ev && (beats == 15)});
        if (ev) begin
          expd = '0;
          for (int i = 0; i < 4; i++) begin
            k = 4 * beats + i;
            t = msg_bits >> (k * mb);
            lane = int'(t[3:0]) & ((1 << mb) - 1);
            expd[16*i +: 16] = lane[15:0];
          end
          chk("out_data", out_data, expd);
        end
        if (prev_stall) begin
          chk("hold_data", out_data, prev_data);
          chk("hold_last", {63'd0, out_last}, {63'd0, prev_last});
        end
        prev_stall = ev && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        was_run = run_m;
        done_m  = 0;
        if (ei && in_valid) begin
          msg_bits[64*ws +: 64] = in_data;
          ws++;
        end
        if (pm) begin
          got_beat[beats] = out_data;
          beats++;
          if (beats == 16) begin
            run_m  = 0;
            done_m = 1;
          end
        end
        if (!was_run && start && (level != 2'b00)) begin
          run_m = 1;
          mb = (level == 2'b01) ? 4 : (level == 2'b10) ? 3 : 2;
          wt = (level == 2'b01) ? 4 : (level == 2'b10) ? 3 : 2;
          ws = 0; beats = 0; msg_bits = '0;
        end
      end
    end
  end

  task automatic run_msg(input logic [1:0] lv, input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, input logic [63:0] w3, input int vprob,
                         input int rprob, input int sprob, input int stall_beat, input int abort_beat);
    logic [63:0] w [4];
    int wi = 0, cyc = 0, stall_n = 0;
    bit fin = 0;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    @(posedge clk); #1;
    start = 1'b1; level = lv;
    @(posedge clk); #1;
    start = 1'b0; level = 2'($urandom);
    while (!fin && cyc < 800) begin
      if (abort_beat >= 0 && beats == abort_beat && run_m) begin
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_out_data", out_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fin = 1;
      end else begin
        in_valid  = (wi < 4) && ($urandom_range(99) < vprob);
        in_data   = in_valid ? w[wi] : {$urandom, $urandom};
        out_ready = ($urandom_range(99) < rprob);
        if (stall_beat >= 0 && beats == stall_beat && stall_n < 5) begin
          out_ready = 1'b0;
          stall_n++;
        end
        start = run_m && (beats < 16) && ($urandom_range(99) < sprob);
        if (start) level = 2'($urandom);
        @(negedge clk);
        if (in_valid && in_ready) wi++;
        if (done) fin = 1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    chk("msg_complete", {63'd0, fin}, 64'd1);
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
  endtask

  initial begin
    logic [63:0] r [4];
    rst_n = 1'b1; start = 1'b0; level = 2'b00;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    armed = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd0);

    // Invalid level must not start a message.
    start = 1'b1; level = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      chk("lvl00_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
    end

    run_msg(2'b01, 64'hFEDCBA9876543210, 64'd0, 64'd0, 64'd0, 100, 100, 0, -1, -1);
    chk("b4_beat0", got_beat[0], 64'h0003000200010000);
    chk("b4_beat3", got_beat[3], 64'h000F000E000D000C);
    chk("b4_beat15", got_beat[15], 64'h0);

    run_msg(2'b11, 64'hFEDCBA9876543210, 64'd0, 64'hDEADBEEF, 64'h1234, 100, 100, 0, -1, -1);
    chk("b2_beat0", got_beat[0], 64'h0000000100000000);

    run_msg(2'b10, 64'h8000000000003210, 64'h0000000000000003, 64'd0, 64'd0, 100, 100, 0, -1, -1);
    chk("b3_beat0", got_beat[0], 64'h0001000000020000);
    chk("b3_coef21", {48'd0, got_beat[5][31:16]}, 64'h7);

    run_msg(2'b01, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 100, 100, 0, 2, -1);
    run_msg(2'b10, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 80, 80, 30, -1, -1);
    run_msg(2'b01, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 100, 100, 0, -1, 7);
    run_msg(2'b01, 64'hFEDCBA9876543210, 64'd0, 64'd0, 64'd0, 100, 100, 0, -1, -1);
    chk("after_abort_beat0", got_beat[0], 64'h0003000200010000);

    for (int m = 0; m < 25; m++) begin
      for (int j = 0; j < 4; j++) r[j] = {$urandom, $urandom};
      run_msg(2'($urandom_range(3, 1)), r[0], r[1], r[2], r[3],
              $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(20), -1, -1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
